// File: rtl/aemb_dwb_lsu.sv
// Data-side load/store unit: one Wishbone classic cycle per memory instruction, big-endian lane handling.
// Optional bus watchdog enabled with `define AEMB_DWB_TIMEOUT_EN (counter width TMO_W).
module aemb_dwb_lsu #(
    parameter int DW    = 32,
    parameter int TMO_W = 8
) (
    input  logic          gclk,
    input  logic          grst,
    input  logic          req_vld,
    input  logic          req_we,
    input  logic [DW-1:2] req_adr,
    input  logic [3:0]    req_sel,
    input  logic [31:0]   req_dat,
    input  logic [4:0]    req_rd,
    output logic [DW-1:2] dwb_adr_o,
    output logic [3:0]    dwb_sel_o,
    output logic [31:0]   dwb_dat_o,
    output logic          dwb_we_o,
    output logic          dwb_stb_o,
    output logic          dwb_cyc_o,
    input  logic [31:0]   dwb_dat_i,
    input  logic          dwb_ack_i,
    output logic          stall_o,
    output logic          ld_vld_o,
    output logic [31:0]   ld_dat_o,
    output logic [4:0]    ld_rd_o,
    output logic          bus_err_o
);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t        state_reg, state_next;
    logic [DW-1:2] adr_reg;
    logic [3:0]    sel_reg;
    logic [31:0]   dat_reg;
    logic          we_reg;
    logic [4:0]    rd_reg;
    logic          ld_vld_reg;
    logic [31:0]   ld_dat_reg;
    logic [4:0]    ld_rd_reg;
    logic          accept, complete, abort, tmo_hit;

    // Stores place the operand on every lane the slave might latch.
    function automatic logic [31:0] replicate(input logic [3:0] sel, input logic [31:0] dat);
        case (sel)
            4'h8, 4'h4, 4'h2, 4'h1: replicate = {4{dat[7:0]}};
            4'hC, 4'h3:             replicate = {2{dat[15:0]}};
            default:                replicate = dat;
        endcase
    endfunction

    function automatic logic [31:0] align(input logic [3:0] sel, input logic [31:0] dat);
        case (sel)
            4'h8:    align = {24'h0, dat[31:24]};
            4'h4:    align = {24'h0, dat[23:16]};
            4'h2:    align = {24'h0, dat[15:8]};
            4'h1:    align = {24'h0, dat[7:0]};
            4'hC:    align = {16'h0, dat[31:16]};
            4'h3:    align = {16'h0, dat[15:0]};
            default: align = dat;
        endcase
    endfunction

    always_comb begin
        state_next = state_reg;
        accept     = 1'b0;
        complete   = 1'b0;
        abort      = 1'b0;
        stall_o    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (req_vld && (req_sel != 4'h0)) begin
                    accept     = 1'b1;
                    state_next = BUSY;
                end
            end
            BUSY: begin
                // Ack takes priority over a watchdog expiry in the same cycle.
                if (dwb_ack_i) begin
                    complete   = 1'b1;
                    state_next = IDLE;
                end else if (tmo_hit) begin
                    abort      = 1'b1;
                    state_next = IDLE;
                end else begin
                    stall_o = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge gclk) begin
        if (!grst) begin
            state_reg  <= IDLE;
            adr_reg    <= '0;
            sel_reg    <= '0;
            dat_reg    <= '0;
            we_reg     <= 1'b0;
            rd_reg     <= '0;
            ld_vld_reg <= 1'b0;
            ld_dat_reg <= '0;
            ld_rd_reg  <= '0;
        end else begin
            state_reg  <= state_next;
            ld_vld_reg <= 1'b0;
            if (accept) begin
                adr_reg <= req_adr;
                sel_reg <= req_sel;
                dat_reg <= replicate(req_sel, req_dat);
                we_reg  <= req_we;
                rd_reg  <= req_rd;
            end
            if (complete || abort) begin
                we_reg <= 1'b0;
            end
            if (complete && !we_reg) begin
                ld_vld_reg <= 1'b1;
                ld_dat_reg <= align(sel_reg, dwb_dat_i);
                ld_rd_reg  <= rd_reg;
            end
        end
    end

`ifdef AEMB_DWB_TIMEOUT_EN
    logic [TMO_W-1:0] tmo_reg;
    logic             err_reg;

    assign tmo_hit = (tmo_reg == {TMO_W{1'b1}});

    always_ff @(posedge gclk) begin
        if (!grst) begin
            tmo_reg <= '0;
            err_reg <= 1'b0;
        end else begin
            err_reg <= abort;
            if (accept) begin
                tmo_reg <= '0;
            end else if ((state_reg == BUSY) && !dwb_ack_i) begin
                tmo_reg <= tmo_reg + 1'b1;
            end
        end
    end

    assign bus_err_o = err_reg;
`else
    logic [TMO_W-1:0] tmo_unused;
    assign tmo_unused = '0;
    assign tmo_hit    = 1'b0;
    assign bus_err_o  = 1'b0;
`endif

    assign dwb_adr_o = adr_reg;
    assign dwb_sel_o = sel_reg;
    assign dwb_dat_o = dat_reg;
    assign dwb_we_o  = we_reg;
    assign dwb_stb_o = (state_reg == BUSY);
    assign dwb_cyc_o = (state_reg == BUSY);
    assign ld_vld_o  = ld_vld_reg;
    assign ld_dat_o  = ld_dat_reg;
    assign ld_rd_o   = ld_rd_reg;

endmodule

// File: tb/tb_aemb_dwb_lsu.sv
// Self-checking bench for aemb_dwb_lsu: directed scenarios plus random transactions against a lane-arithmetic model.
// Watchdog scenarios run when AEMB_DWB_TIMEOUT_EN is defined (TMO_W forced to 3).
module tb_aemb_dwb_lsu;

`ifdef AEMB_DWB_TIMEOUT_EN
    localparam int TB_TMO = 3;
`else
    localparam int TB_TMO = 8;
`endif

    logic        gclk = 1'b0;
    logic        grst;
    logic        req_vld, req_we;
    logic [31:2] req_adr;
    logic [3:0]  req_sel;
    logic [31:0] req_dat;
    logic [4:0]  req_rd;
    logic [31:2] dwb_adr_o;
    logic [3:0]  dwb_sel_o;
    logic [31:0] dwb_dat_o;
    logic        dwb_we_o, dwb_stb_o, dwb_cyc_o;
    logic [31:0] dwb_dat_i;
    logic        dwb_ack_i;
    logic        stall_o, ld_vld_o;
    logic [31:0] ld_dat_o;
    logic [4:0]  ld_rd_o;
    logic        bus_err_o;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] last_ld_dat;
    logic [4:0]  last_ld_rd;
    logic [3:0]  sel_tab [7] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'hC, 4'hF};

    always #5 gclk = ~gclk;

    aemb_dwb_lsu #(.DW(32), .TMO_W(TB_TMO)) dut (
        .gclk(gclk), .grst(grst),
        .req_vld(req_vld), .req_we(req_we), .req_adr(req_adr), .req_sel(req_sel),
        .req_dat(req_dat), .req_rd(req_rd),
        .dwb_adr_o(dwb_adr_o), .dwb_sel_o(dwb_sel_o), .dwb_dat_o(dwb_dat_o),
        .dwb_we_o(dwb_we_o), .dwb_stb_o(dwb_stb_o), .dwb_cyc_o(dwb_cyc_o),
        .dwb_dat_i(dwb_dat_i), .dwb_ack_i(dwb_ack_i),
        .stall_o(stall_o), .ld_vld_o(ld_vld_o), .ld_dat_o(ld_dat_o), .ld_rd_o(ld_rd_o),
        .bus_err_o(bus_err_o)
    );

    // Model: store data is the operand repeated across lanes by multiplication.
    function automatic logic [31:0] model_store(input logic [3:0] sel, input logic [31:0] d);
        if (sel == 4'h1 || sel == 4'h2 || sel == 4'h4 || sel == 4'h8)
            return (d & 32'hFF) * 32'h01010101;
        if (sel == 4'h3 || sel == 4'hC)
            return (d & 32'hFFFF) * 32'h00010001;
        return d;
    endfunction

    // Model: lane k (bit k of sel) holds bits 8k+7:8k of the bus word.
    function automatic logic [31:0] model_load(input logic [3:0] sel, input logic [31:0] d);
        for (int k = 0; k < 4; k++)
            if (sel == (4'h1 << k)) return (d >> (8 * k)) & 32'hFF;
        if (sel == 4'hC) return d >> 16;
        if (sel == 4'h3) return d & 32'hFFFF;
        return d;
    endfunction

    task automatic run_txn(input logic we, input logic [31:2] adr, input logic [3:0] sel,
                           input logic [31:0] dat, input logic [4:0] rd, input int wait_n,
                           input logic hold, input logic [31:0] rdata, input string tag);
        logic [68:0] exp_bus;
        logic [31:0] exp_ld;
        int stalls = 0;
        exp_bus = {1'b1, 1'b1, we, sel, adr, model_store(sel, dat)};
        exp_ld  = model_load(sel, rdata);
        @(negedge gclk);
        req_vld = 1'b1; req_we = we; req_adr = adr; req_sel = sel; req_dat = dat; req_rd = rd;
        dwb_ack_i = 1'b0;
        #1;
        n_cmp++;
        if (stall_o !== 1'b0) begin n_bad++; $display("FAIL %s accept_stall: got %b want 0", tag, stall_o); end
        @(negedge gclk);
        if (!hold) begin
            req_vld = 1'b0; req_we = ~we; req_adr = $urandom; req_sel = 4'($urandom);
            req_dat = $urandom; req_rd = 5'($urandom);
        end
        for (int i = 0; i < wait_n; i++) begin
            #1;
            if (stall_o) stalls++;
            n_cmp++;
            if ({dwb_stb_o, dwb_cyc_o, dwb_we_o, dwb_sel_o, dwb_adr_o, dwb_dat_o} !== exp_bus) begin
                n_bad++;
                $display("FAIL %s bus_hold: got %h want %h",
                         tag, {dwb_stb_o, dwb_cyc_o, dwb_we_o, dwb_sel_o, dwb_adr_o, dwb_dat_o}, exp_bus);
            end
            n_cmp++;
            if (ld_vld_o !== 1'b0) begin n_bad++; $display("FAIL %s busy_ld_vld: got %b want 0", tag, ld_vld_o); end
            @(negedge gclk);
        end
        dwb_dat_i = rdata; dwb_ack_i = 1'b1;
        #1;
        n_cmp++;
        if ({stall_o, dwb_stb_o, dwb_cyc_o, dwb_we_o, dwb_sel_o, dwb_adr_o, dwb_dat_o} !== {1'b0, exp_bus}) begin
            n_bad++;
            $display("FAIL %s ack_cycle: got %h want %h", tag,
                     {stall_o, dwb_stb_o, dwb_cyc_o, dwb_we_o, dwb_sel_o, dwb_adr_o, dwb_dat_o}, {1'b0, exp_bus});
        end
        @(negedge gclk);
        dwb_ack_i = 1'b0; req_vld = 1'b0; dwb_dat_i = $urandom;
        #1;
        n_cmp++;
        if (stalls != wait_n) begin n_bad++; $display("FAIL %s stall_count: got %0d want %0d", tag, stalls, wait_n); end
        n_cmp++;
        if ({dwb_stb_o, dwb_cyc_o, dwb_we_o, bus_err_o, ld_vld_o} !== {4'b0, ~we}) begin
            n_bad++;
            $display("FAIL %s done_flags: got %b want %b", tag,
                     {dwb_stb_o, dwb_cyc_o, dwb_we_o, bus_err_o, ld_vld_o}, {4'b0, ~we});
        end
        if (!we) begin
            last_ld_dat = exp_ld; last_ld_rd = rd;
        end
        n_cmp++;
        if ({ld_dat_o, ld_rd_o} !== {last_ld_dat, last_ld_rd}) begin
            n_bad++;
            $display("FAIL %s ld_result: got %h/%0d want %h/%0d", tag, ld_dat_o, ld_rd_o, last_ld_dat, last_ld_rd);
        end
        @(negedge gclk);
        #1;
        n_cmp++;
        if ({dwb_stb_o, ld_vld_o, ld_dat_o, ld_rd_o} !== {2'b00, last_ld_dat, last_ld_rd}) begin
            n_bad++;
            $display("FAIL %s after_done: got stb=%b vld=%b %h/%0d want stb=0 vld=0 %h/%0d", tag,
                     dwb_stb_o, ld_vld_o, ld_dat_o, ld_rd_o, last_ld_dat, last_ld_rd);
        end
        $display("txn %s we=%0d adr=%h sel=%h dat=%h rd=%0d wait=%0d hold=%0d rdata=%h",
                 tag, we, adr, sel, dat, rd, wait_n, hold, rdata);
    endtask

    task automatic test_reset();
        grst = 1'b0; req_vld = 1'b0; req_we = 1'b0; req_adr = '0; req_sel = '0; req_dat = '0; req_rd = '0;
        dwb_dat_i = '0; dwb_ack_i = 1'b0;
        repeat (2) @(negedge gclk);
        #1;
        n_cmp++;
        if ({dwb_adr_o, dwb_sel_o, dwb_dat_o, dwb_we_o, dwb_stb_o, dwb_cyc_o, stall_o,
             ld_vld_o, ld_dat_o, ld_rd_o, bus_err_o} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: got stb=%b vld=%b dat=%h ld=%h want all 0", dwb_stb_o, ld_vld_o, dwb_dat_o, ld_dat_o);
        end
        grst = 1'b1;
        last_ld_dat = '0; last_ld_rd = '0;
        $display("txn reset");
    endtask

    task automatic test_reset_mid();
        @(negedge gclk);
        req_vld = 1'b1; req_we = 1'b0; req_adr = 30'h55; req_sel = 4'hF; req_dat = 32'h1; req_rd = 5'd9;
        @(negedge gclk);
        req_vld = 1'b0;
        #1;
        n_cmp++;
        if (dwb_stb_o !== 1'b1) begin n_bad++; $display("FAIL rstmid_busy: got stb=%b want 1", dwb_stb_o); end
        grst = 1'b0; dwb_ack_i = 1'b1; dwb_dat_i = 32'hDEADBEEF;
        for (int i = 0; i < 2; i++) begin
            @(negedge gclk);
            #1;
            n_cmp++;
            if ({dwb_adr_o, dwb_sel_o, dwb_dat_o, dwb_we_o, dwb_stb_o, dwb_cyc_o, stall_o,
                 ld_vld_o, ld_dat_o, ld_rd_o, bus_err_o} !== '0) begin
                n_bad++;
                $display("FAIL rstmid_outputs: got stb=%b cyc=%b vld=%b ld=%h want all 0", dwb_stb_o, dwb_cyc_o, ld_vld_o, ld_dat_o);
            end
        end
        grst = 1'b1; dwb_ack_i = 1'b0;
        last_ld_dat = '0; last_ld_rd = '0;
        @(negedge gclk);
        #1;
        n_cmp++;
        if ({dwb_stb_o, ld_vld_o} !== 2'b00) begin
            n_bad++; $display("FAIL rstmid_idle: got stb=%b vld=%b want 0 0", dwb_stb_o, ld_vld_o);
        end
        $display("txn reset_mid_transaction");
    endtask

    task automatic test_byte_store();
        run_txn(1'b1, 30'h100, 4'h4, 32'h000000A5, 5'd3, 3, 1'b0, 32'h0, "byte_store");
    endtask

    task automatic test_half_load();
        run_txn(1'b0, 30'h2A, 4'h3, 32'hFFFF0000, 5'd7, 0, 1'b0, 32'h1234ABCD, "half_load");
    endtask

    task automatic test_held_request();
        run_txn(1'b0, 30'h3F0, 4'hC, 32'h0, 5'd12, 2, 1'b1, 32'hCAFE1234, "held_req");
    endtask

    task automatic test_stray_ack();
        @(negedge gclk);
        req_vld = 1'b0; dwb_ack_i = 1'b1; dwb_dat_i = 32'h87654321;
        for (int i = 0; i < 3; i++) begin
            @(negedge gclk);
            #1;
            n_cmp++;
            if ({dwb_stb_o, stall_o, ld_vld_o, ld_dat_o, ld_rd_o} !== {3'b000, last_ld_dat, last_ld_rd}) begin
                n_bad++;
                $display("FAIL stray_ack: got stb=%b stall=%b vld=%b %h want 0 0 0 %h",
                         dwb_stb_o, stall_o, ld_vld_o, ld_dat_o, last_ld_dat);
            end
        end
        dwb_ack_i = 1'b0;
        $display("txn stray_ack");
    endtask

    task automatic test_sel_zero();
        @(negedge gclk);
        req_vld = 1'b1; req_sel = 4'h0; req_we = 1'b1; req_adr = 30'h77; req_dat = 32'h11223344;
        for (int i = 0; i < 3; i++) begin
            @(negedge gclk);
            #1;
            n_cmp++;
            if ({dwb_stb_o, dwb_cyc_o, stall_o} !== 3'b000) begin
                n_bad++; $display("FAIL sel_zero: got stb=%b cyc=%b stall=%b want 000", dwb_stb_o, dwb_cyc_o, stall_o);
            end
        end
        req_vld = 1'b0;
        $display("txn sel_zero");
    endtask

    task automatic test_random();
        for (int n = 0; n < 24; n++) begin
            run_txn(1'($urandom), 30'($urandom), sel_tab[$urandom_range(0, 6)], $urandom,
                    5'($urandom), $urandom_range(0, 5), 1'($urandom), $urandom, "random");
        end
    endtask

`ifdef AEMB_DWB_TIMEOUT_EN
    task automatic test_timeout();
        int stalls = 0;
        @(negedge gclk);
        req_vld = 1'b1; req_we = 1'b0; req_adr = 30'h44; req_sel = 4'hF; req_rd = 5'd4; dwb_ack_i = 1'b0;
        @(negedge gclk);
        req_vld = 1'b0;
        #1;
        while (stall_o && stalls < 20) begin
            stalls++;
            @(negedge gclk);
            #1;
        end
        n_cmp++;
        if (stalls != 7) begin n_bad++; $display("FAIL tmo_stall_count: got %0d want 7", stalls); end
        n_cmp++;
        if (dwb_stb_o !== 1'b1) begin n_bad++; $display("FAIL tmo_abort_cycle: got stb=%b want 1", dwb_stb_o); end
        @(negedge gclk);
        #1;
        n_cmp++;
        if ({dwb_stb_o, dwb_cyc_o, dwb_we_o, bus_err_o, ld_vld_o} !== 5'b00010) begin
            n_bad++;
            $display("FAIL tmo_abort: got %b want 00010", {dwb_stb_o, dwb_cyc_o, dwb_we_o, bus_err_o, ld_vld_o});
        end
        @(negedge gclk);
        #1;
        n_cmp++;
        if (bus_err_o !== 1'b0) begin n_bad++; $display("FAIL tmo_err_pulse: got %b want 0", bus_err_o); end
        $display("txn timeout_abort stalls=%0d", stalls);
        run_txn(1'b0, 30'h45, 4'h2, 32'h0, 5'd5, 7, 1'b0, 32'h00C30000 | 32'h0000AB00, "tmo_ack_wins");
    endtask
`endif

    initial begin
        test_reset();
        test_byte_store();
        test_half_load();
        test_held_request();
        test_stray_ack();
        test_sel_zero();
        test_random();
        test_reset_mid();
        test_half_load();
`ifdef AEMB_DWB_TIMEOUT_EN
        test_timeout();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
